// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit 7-segment scan driver.
// One anode is lit at a time for REFRESH_DIV clocks; loads are held in a pending
// buffer and copied into the displayed (shadow) buffer only at the frame boundary,
// so a frame never mixes old and new data.
// Optional build macro: LEADING_ZERO_BLANK_EN -- darkens digits above the highest
// nonzero nibble of the displayed value (digit 0 always shown, dp keeps a digit lit).
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1024,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank_in,
   output logic [6:0]          segments,
   output logic                decimal_point,
   output logic [DIGITS-1:0]   anode,
   output logic                frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF    = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{ACTIVE_LOW}};

   // Scan position
   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;

   // Pending (last load) and shadow (on display) buffers
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d, shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, shadow_blank_q, shadow_blank_d;
   logic                pend_flag_q, pend_flag_d;

   // Registered outputs
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              tick_q, tick_d;

   logic              slot_end, frame_end;
   logic [DIGITS-1:0] blank_eff;
   logic [3:0]        nib;
   logic              dp_sel, dark;
   logic [6:0]        seg_act;
   logic [DIGITS-1:0] an_act;

   // Active-high abcdefg font, bit 0 = segment a
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   // Prescaler/index advance and the double-buffer hand-over at the frame boundary
   always_comb begin
      slot_end  = (presc_q == PRESC_LAST);
      frame_end = slot_end && (idx_q == IDX_LAST);
      presc_d   = slot_end ? '0 : presc_q + 1'b1;
      idx_d     = idx_q;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      shadow_val_d   = shadow_val_q;
      shadow_dp_d    = shadow_dp_q;
      shadow_blank_d = shadow_blank_q;
      pend_val_d     = pend_val_q;
      pend_dp_d      = pend_dp_q;
      pend_blank_d   = pend_blank_q;
      pend_flag_d    = pend_flag_q;
      if (frame_end && pend_flag_q) begin
         shadow_val_d   = pend_val_q;
         shadow_dp_d    = pend_dp_q;
         shadow_blank_d = pend_blank_q;
         pend_flag_d    = 1'b0;
      end
      // A load on the boundary cycle refills pending after the old contents moved out
      if (load) begin
         pend_val_d   = value;
         pend_dp_d    = dp_in;
         pend_blank_d = blank_in;
         pend_flag_d  = 1'b1;
      end
   end

   // Effective per-digit blanking from the shadow buffer
   always_comb begin
      blank_eff = shadow_blank_q;
`ifdef LEADING_ZERO_BLANK_EN
      begin
         logic seen_nz;
         seen_nz = 1'b0;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (shadow_val_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
            if (!seen_nz && !shadow_dp_q[i]) blank_eff[i] = 1'b1;
         end
      end
`endif
   end

   // Select the active digit and build next output values with polarity applied
   always_comb begin
      nib    = 4'h0;
      dp_sel = 1'b0;
      dark   = 1'b1;
      an_act = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib       = shadow_val_q[4*i +: 4];
            dp_sel    = shadow_dp_q[i];
            dark      = blank_eff[i];
            an_act[i] = ~blank_eff[i];
         end
      end
      seg_act = dark ? 7'h00 : hex_to_seg(nib);
      seg_d   = ACTIVE_LOW ? ~seg_act : seg_act;
      dp_d    = ACTIVE_LOW ? ~(dp_sel & ~dark) : (dp_sel & ~dark);
      an_d    = ACTIVE_LOW ? ~an_act : an_act;
      tick_d  = frame_end;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q        <= '0;
         idx_q          <= '0;
         pend_val_q     <= '0;
         pend_dp_q      <= '0;
         pend_blank_q   <= '0;
         pend_flag_q    <= 1'b0;
         shadow_val_q   <= '0;
         shadow_dp_q    <= '0;
         shadow_blank_q <= '0;
         seg_q          <= SEG_OFF;
         dp_q           <= ACTIVE_LOW;
         an_q           <= AN_OFF;
         tick_q         <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         idx_q          <= idx_d;
         pend_val_q     <= pend_val_d;
         pend_dp_q      <= pend_dp_d;
         pend_blank_q   <= pend_blank_d;
         pend_flag_q    <= pend_flag_d;
         shadow_val_q   <= shadow_val_d;
         shadow_dp_q    <= shadow_dp_d;
         shadow_blank_q <= shadow_blank_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         an_q           <= an_d;
         tick_q         <= tick_d;
      end
   end

   assign segments      = seg_q;
   assign decimal_point = dp_q;
   assign anode         = an_q;
   assign frame_tick    = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
// A cycle-count based reference model predicts every registered output.
module tb_seg7_scan_driver;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int FRAME  = DIGITS * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic [6:0]  segments;
   logic        decimal_point;
   logic [3:0]  anode;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   // Clock
   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DIGITS(DIGITS), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
      .blank_in(blank_in), .segments(segments), .decimal_point(decimal_point),
      .anode(anode), .frame_tick(frame_tick)
   );

   // ---------------- reference model ----------------
   logic [6:0] hex_font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int          m_cnt = 0;   // clocks since reset release, modulo one frame
   logic [15:0] m_pend_v = '0, m_sh_v = '0;
   logic [3:0]  m_pend_dp = '0, m_sh_dp = '0, m_pend_bl = '0, m_sh_bl = '0;
   bit          m_pend_f = 1'b0;
   logic [3:0]  exp_anode;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_tick;

   // Active-low {anode, segments, dp} for the digit lit at clock count cnt
   function automatic logic [11:0] model_out(input int cnt, input logic [15:0] sv,
                                             input logic [3:0] sdp, input logic [3:0] sbl);
      int d;
      bit dark;
      logic [3:0] n;
      d    = cnt / DIV;
      dark = sbl[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && 32'(sv) < (32'd1 << (4 * d)) && !sdp[d]) dark = 1'b1;
`endif
      n = 4'((sv >> (4 * d)) & 16'hF);
      if (dark) return {4'hF, 7'h7F, 1'b1};
      return {~(4'b0001 << d), ~hex_font[n], ~sdp[d]};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_cnt <= 0;
         m_pend_v <= '0; m_pend_dp <= '0; m_pend_bl <= '0; m_pend_f <= 1'b0;
         m_sh_v <= '0; m_sh_dp <= '0; m_sh_bl <= '0;
         {exp_anode, exp_seg, exp_dp} <= {4'hF, 7'h7F, 1'b1};
         exp_tick <= 1'b0;
      end else begin
         {exp_anode, exp_seg, exp_dp} <= model_out(m_cnt, m_sh_v, m_sh_dp, m_sh_bl);
         exp_tick <= (m_cnt == FRAME - 1);
         if (m_cnt == FRAME - 1 && m_pend_f) begin
            m_sh_v <= m_pend_v; m_sh_dp <= m_pend_dp; m_sh_bl <= m_pend_bl;
            m_pend_f <= 1'b0;
         end
         if (load) begin
            m_pend_v <= value; m_pend_dp <= dp_in; m_pend_bl <= blank_in;
            m_pend_f <= 1'b1;
         end
         m_cnt <= (m_cnt + 1) % FRAME;
      end
   end

   // ---------------- driver ----------------
   // Called at a falling edge: apply inputs, let one rising edge pass, return at the next falling edge
   task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      load = ld; value = v; dp_in = dp; blank_in = bl;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < FRAME && m_cnt != target; i++) cyc(1'b0, value, dp_in, blank_in);
   endtask

   function automatic int lit_digit(input logic [3:0] an);
      case (an)
         4'hE: return 0;
         4'hD: return 1;
         4'hB: return 2;
         4'h7: return 3;
         default: return -1;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      int ticks;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0, 4'h0, 4'h0);
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got an=%h seg=%h dp=%b tick=%b, want an=F seg=7F dp=1 tick=0",
                     anode, segments, decimal_point, frame_tick);
         end
      end
      reset = 1'b0;
      cyc(1'b0, 16'h0, 4'h0, 4'h0);
      checks++;
      if ({anode, segments, decimal_point} !== {4'hE, 7'h40, 1'b1}) begin
         errors++;
         $display("FAIL reset_release: got an=%h seg=%h dp=%b, want an=E seg=40 dp=1",
                  anode, segments, decimal_point);
      end
      ticks = 0;
      for (int i = 0; i < 2 * FRAME - 1; i++) begin
         cyc(1'b0, 16'h0, 4'h0, 4'h0);
         if (frame_tick === 1'b1) ticks++;
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL scan_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
      end
      checks++;
      if (ticks !== 2) begin
         errors++;
         $display("FAIL frame_tick_count: got %0d pulses, want 2", ticks);
      end
   endtask

   task automatic test_load_midframe();
      logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
      int d;
      idle_until(5);
      cyc(1'b1, 16'h1234, 4'h0, 4'h0);
      for (int i = 0; i < 2 * FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL load_mid_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
      end
      for (int i = 0; i < FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         d = lit_digit(anode);
         if (d >= 0) begin
            checks++;
            if (segments !== want[d]) begin
               errors++;
               $display("FAIL load_1234_digit%0d: got seg=%h, want %h", d, segments, want[d]);
            end
         end
      end
   endtask

   task automatic test_last_load_wins();
      int seen_old;
      idle_until(1);
      cyc(1'b1, 16'hABCD, 4'h0, 4'h0);
      cyc(1'b0, value, dp_in, blank_in);
      cyc(1'b0, value, dp_in, blank_in);
      cyc(1'b1, 16'h00F0, 4'h0, 4'h0);
      seen_old = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         if (anode === 4'h7 && segments === 7'h08) seen_old++;
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL last_load_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
      end
      checks++;
      if (seen_old !== 0) begin
         errors++;
         $display("FAIL last_load_no_ABCD: got %0d cycles showing 'A' on digit3, want 0", seen_old);
      end
   endtask

   task automatic test_boundary_load();
      idle_until(2);
      cyc(1'b1, 16'h5A5A, 4'h0, 4'h0);
      idle_until(FRAME - 1);
      cyc(1'b1, 16'h1F2E, 4'h0, 4'h0);
      cyc(1'b0, value, dp_in, blank_in);
      checks++;
      if ({anode, segments} !== {4'hE, 7'h08}) begin
         errors++;
         $display("FAIL boundary_old_pending: got an=%h seg=%h, want an=E seg=08", anode, segments);
      end
      for (int i = 0; i < FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL boundary_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
      end
      checks++;
      if ({anode, segments} !== {4'hE, 7'h06}) begin
         errors++;
         $display("FAIL boundary_new_next_frame: got an=%h seg=%h, want an=E seg=06", anode, segments);
      end
   endtask

   task automatic test_blank();
      cyc(1'b1, 16'h8888, 4'b0001, 4'b1010);
      for (int i = 0; i < 3 * FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL blank_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
         if (i >= FRAME) begin
            checks++;
            if (anode[1] !== 1'b1 || anode[3] !== 1'b1 || $countones(~anode) > 1) begin
               errors++;
               $display("FAIL blank_anodes: got an=%h, want digits 1,3 dark and at most one lit", anode);
            end
            if (anode === 4'hE) begin
               checks++;
               if (decimal_point !== 1'b0) begin
                  errors++;
                  $display("FAIL blank_dp_digit0: got dp=%b, want 0", decimal_point);
               end
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [15:0] vals [2] = '{16'h0050, 16'h0000};
      logic [3:0]  lit;
      logic [6:0]  seg_seen [4];
      int d;
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, vals[k], 4'h0, 4'h0);
         for (int i = 0; i < FRAME + 1; i++) cyc(1'b0, value, dp_in, blank_in);
         lit = '0;
         for (int j = 0; j < 4; j++) seg_seen[j] = 7'h7F;
         for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, value, dp_in, blank_in);
            d = lit_digit(anode);
            if (d >= 0) begin
               lit[d] = 1'b1;
               seg_seen[d] = segments;
            end
         end
`ifdef LEADING_ZERO_BLANK_EN
         checks++;
         if (lit !== ((k == 0) ? 4'b0011 : 4'b0001)) begin
            errors++;
            $display("FAIL lzb_lit_mask: value=%h got lit=%b, want %b", vals[k], lit, (k == 0) ? 4'b0011 : 4'b0001);
         end
`else
         checks++;
         if (lit !== 4'b1111) begin
            errors++;
            $display("FAIL lzb_off_lit_mask: value=%h got lit=%b, want 1111", vals[k], lit);
         end
`endif
         checks++;
         if (seg_seen[0] !== 7'h40) begin
            errors++;
            $display("FAIL lzb_digit0: value=%h got seg=%h, want 40", vals[k], seg_seen[0]);
         end
         if (k == 0) begin
            checks++;
            if (seg_seen[1] !== 7'h12) begin
               errors++;
               $display("FAIL lzb_digit1: got seg=%h, want 12", seg_seen[1]);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int seen7;
      cyc(1'b1, 16'h7777, 4'hF, 4'h0);
      cyc(1'b0, value, dp_in, blank_in);
      reset = 1'b1;
      cyc(1'b0, value, dp_in, blank_in);
      reset = 1'b0;
      checks++;
      if ({anode, segments, decimal_point, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got an=%h seg=%h dp=%b tick=%b, want an=F seg=7F dp=1 tick=0",
                  anode, segments, decimal_point, frame_tick);
      end
      seen7 = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cyc(1'b0, value, dp_in, blank_in);
         if (segments === 7'h78) seen7++;
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL reset_mid_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
      end
      checks++;
      if (seen7 !== 0) begin
         errors++;
         $display("FAIL reset_discards_pending: got %0d cycles showing '7', want 0", seen7);
      end
   endtask

   task automatic test_random();
      bit ld;
      for (int i = 0; i < 300; i++) begin
         ld = ($urandom_range(0, 7) == 0);
         if (ld) cyc(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         else    cyc(1'b0, value, dp_in, blank_in);
         checks++;
         if ({anode, segments, decimal_point, frame_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL random_model: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                     anode, segments, decimal_point, frame_tick, exp_anode, exp_seg, exp_dp, exp_tick);
         end
         checks++;
         if ($countones(~anode) > 1) begin
            errors++;
            $display("FAIL random_onehot: got an=%h, want at most one digit lit", anode);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_midframe();
      test_last_load_wins();
      test_boundary_load();
      test_blank();
      test_leading_zero();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
